bit64_subtractor_core: RTL and testbench
========================================

Name: bit64_subtractor_core

Overview:
- Registered 64-bit two's-complement subtractor for the pipelined datapath's integer execute stage.
- Computes difference = a − b as a + ~b + 1 and produces borrow (unsigned) and overflow (signed) flags.
- Results are captured in output registers, giving one cycle of latency under a valid qualifier.

Parameters:
- WIDTH, 64, operand and result width in bits. The datapath uses 64; the logic must be correct for any WIDTH ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  WIDTH  minuend, signed two's complement
- b  input  WIDTH  subtrahend, signed two's complement
- out_valid  output  1  registered results valid
- difference  output  WIDTH  registered a − b, modulo 2^WIDTH
- borrow  output  1  registered unsigned borrow
- overflow  output  1  registered signed overflow
- zero  output  1  registered difference==0; present only with SUB_ZERO_FLAG_EN

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous assert, synchronous release on the next clk edge): out_valid=0, difference=0, borrow=0, overflow=0, zero=0.
- Datapath is combinational:
  - d_raw = a + (~b) + 1, evaluated as a ripple-borrow or carry-lookahead chain of full-adder cells with carry-in 1.
  - cout = carry out of the MSB cell.
- Flags:
  - borrow = ~cout, equivalent to (unsigned a < unsigned b).
  - overflow = (a[MSB] != b[MSB]) && (d_raw[MSB] != a[MSB]).
- Latency: 1 cycle.
  - On a clk rising edge with in_valid=1: difference, borrow, overflow (and zero) load the combinational results, and out_valid becomes 1.
  - On a rising edge with in_valid=0: out_valid becomes 0; difference and the flags hold their previous values.
- Throughput: one operation per cycle. There is no backpressure; back-to-back valid inputs produce back-to-back valid outputs.
- Result registers must never change except on a valid capture or on reset.
- Reset asserted mid-operation: all outputs clear immediately, and any in-flight result is discarded.
- Boundary cases:
  - a == b: difference=0, borrow=0, overflow=0.
  - b == 0: difference=a, borrow=0, overflow=0.
  - a − MIN_NEG with a ≥ 0: overflow=1.
  - MIN_NEG − positive: overflow=1.
  - No saturation; the result always wraps.

Optional Feature:
- Macro: SUB_ZERO_FLAG_EN.
- When defined: the zero output port exists. zero is registered alongside the other flags, equals 1 iff d_raw == 0 at the capture edge, holds while in_valid=0, and resets to 0.
- When undefined: the zero port and its register are absent. All other behaviour is identical.

Test Plan:
- Basic subtract: a=7, b=2, in_valid=1 → next cycle out_valid=1, difference=5, borrow=0, overflow=0.
- Negative subtrahend: a=3, b=−4 (0xFFFF_FFFF_FFFF_FFFC) → difference=7, borrow=1, overflow=0.
- Negative results:
  - a=−2, b=5 → difference=−7 (0xFFFF_FFFF_FFFF_FFF9), borrow=0, overflow=0.
  - a=−8, b=1 → difference=−9 (0xFFFF_FFFF_FFFF_FFF7), borrow=0, overflow=0.
- Overflow corners:
  - a=0x8000_0000_0000_0000, b=1 → difference=0x7FFF_FFFF_FFFF_FFFF, overflow=1, borrow=0.
  - a=0, b=0x8000_0000_0000_0000 → difference=0x8000_0000_0000_0000, overflow=1, borrow=1.
  - a=b=0x1234 → difference=0, zero=1 (with macro), borrow=0, overflow=0.
- Control: drop in_valid after one op → out_valid=0 and difference holds its last value. Assert rst_n=0 mid-stream → all outputs 0 immediately, without waiting for clk. Release reset, issue valid ops on 3 consecutive cycles → 3 consecutive correct results, each 1 cycle later.

Source files
------------

// File: rtl/bit64_subtractor_core_if.sv
// rtl/bit64_subtractor_core_if.sv - operand/result bundle for the registered subtractor
// The zero flag signal exists only when SUB_ZERO_FLAG_EN is defined.
interface bit64_subtractor_core_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] difference;
  logic             borrow;
  logic             overflow;
`ifdef SUB_ZERO_FLAG_EN
  logic             zero;

  modport master (
    output in_valid, a, b,
    input  out_valid, difference, borrow, overflow, zero
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, difference, borrow, overflow, zero
  );
`else
  modport master (
    output in_valid, a, b,
    input  out_valid, difference, borrow, overflow
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, difference, borrow, overflow
  );
`endif
endinterface

// File: rtl/bit64_subtractor_core.sv
// rtl/bit64_subtractor_core.sv - registered two's-complement subtractor with borrow/overflow flags
// Optional registered zero flag is enabled by defining SUB_ZERO_FLAG_EN.
module bit64_subtractor_core #(
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bit64_subtractor_core_if.slave  bus
);

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] d_raw;
  logic [WIDTH:0]   carry;
  logic             borrow_c;
  logic             overflow_c;

  // a + ~b + 1 as a ripple chain of full-adder cells, carry-in tied high
  always_comb begin
    nb       = ~bus.b;
    d_raw    = '0;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      d_raw[i]     = bus.a[i] ^ nb[i] ^ carry[i];
      carry[i + 1] = (bus.a[i] & nb[i]) | (carry[i] & (bus.a[i] ^ nb[i]));
    end
  end

  assign borrow_c   = ~carry[WIDTH];
  assign overflow_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                      (d_raw[WIDTH-1] != bus.a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.difference <= '0;
      bus.borrow     <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      // result registers only move on a valid capture
      if (bus.in_valid) begin
        bus.difference <= d_raw;
        bus.borrow     <= borrow_c;
        bus.overflow   <= overflow_c;
      end
    end
  end

`ifdef SUB_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.zero <= 1'b0;
    end else if (bus.in_valid) begin
      bus.zero <= (d_raw == '0);
    end
  end
`endif

endmodule

// File: tb/tb_bit64_subtractor_core.sv
// tb/tb_bit64_subtractor_core.sv - randomized self-checking bench for bit64_subtractor_core
// Checks the zero flag as well when SUB_ZERO_FLAG_EN is defined.
module tb_bit64_subtractor_core;

  localparam logic signed [64:0] MAXP = {1'b0, 64'h7FFF_FFFF_FFFF_FFFF};
  localparam logic signed [64:0] MINN = {1'b1, 64'h8000_0000_0000_0000};

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  // reference state: what the outputs must show after each edge
  logic        m_valid;
  logic [63:0] m_diff;
  logic        m_borrow;
  logic        m_ovf;
  logic        m_zero;

  bit64_subtractor_core_if #(.WIDTH(64)) bus ();

  bit64_subtractor_core #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] diff;
    logic        borrow;
    logic        ovf;
  } vec_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic ref_overflow(input logic [63:0] x, input logic [63:0] y);
    logic signed [64:0] full;
    full = $signed({x[63], x}) - $signed({y[63], y});
    return (full > MAXP) || (full < MINN);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"},    64'(bus.out_valid),  64'(m_valid));
    check({tag, ".diff"},     bus.difference,      m_diff);
    check({tag, ".borrow"},   64'(bus.borrow),     64'(m_borrow));
    check({tag, ".overflow"}, 64'(bus.overflow),   64'(m_ovf));
`ifdef SUB_ZERO_FLAG_EN
    check({tag, ".zero"},     64'(bus.zero),       64'(m_zero));
`endif
  endtask

  // drive one cycle of inputs, advance the model across the edge, then check
  task automatic step(input string tag, input logic v, input logic [63:0] xa, input logic [63:0] xb);
    bus.in_valid = v;
    bus.a        = xa;
    bus.b        = xb;
    @(posedge clk);
    if (rst_n) begin
      m_valid = v;
      if (v) begin
        m_diff   = xa - xb;
        m_borrow = xa < xb;
        m_ovf    = ref_overflow(xa, xb);
        m_zero   = (xa == xb);
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_diff   = '0;
    m_borrow = 1'b0;
    m_ovf    = 1'b0;
    m_zero   = 1'b0;
  endtask

  function automatic logic [63:0] pick_operand(input logic [63:0] other);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return other;
      5: return 64'($urandom_range(0, 15));
      default: return r;
    endcase
  endfunction

  vec_t vecs[7];

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    rst_n        = 1'b0;
    model_reset();

    vecs[0] = '{64'd7, 64'd2, 64'd5, 1'b0, 1'b0};
    vecs[1] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'd7, 1'b1, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'd1, 64'hFFFF_FFFF_FFFF_FFF7, 1'b0, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[5] = '{64'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[6] = '{64'h1234, 64'h1234, 64'd0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;

    // directed cases against hand-derived constants
    foreach (vecs[i]) begin
      step($sformatf("dir%0d", i), 1'b1, vecs[i].a, vecs[i].b);
      check($sformatf("dir%0d.const_diff", i), bus.difference, vecs[i].diff);
      check($sformatf("dir%0d.const_borrow", i), 64'(bus.borrow), 64'(vecs[i].borrow));
      check($sformatf("dir%0d.const_ovf", i), 64'(bus.overflow), 64'(vecs[i].ovf));
    end
`ifdef SUB_ZERO_FLAG_EN
    check("dir6.const_zero", 64'(bus.zero), 64'd1);
`endif

    // drop in_valid: results hold
    step("hold0", 1'b1, 64'd100, 64'd58);
    step("hold1", 1'b0, 64'd1, 64'd2);
    check("hold.const_diff", bus.difference, 64'd42);
    step("hold2", 1'b0, 64'h5555, 64'hAAAA);

    // async reset mid-stream, observed before any clock edge
    step("pre_rst", 1'b1, 64'h8000_0000_0000_0000, 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    step("in_rst", 1'b1, 64'd9, 64'd4);
    #2;
    rst_n = 1'b1;

    // three back-to-back operations
    step("b2b0", 1'b1, 64'd10, 64'd3);
    check("b2b0.const_diff", bus.difference, 64'd7);
    step("b2b1", 1'b1, 64'd0, 64'd1);
    check("b2b1.const_diff", bus.difference, 64'hFFFF_FFFF_FFFF_FFFF);
    step("b2b2", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b2.const_ovf", 64'(bus.overflow), 64'd1);

    // randomized stream with corner-biased operands
    for (int n = 0; n < 300; n++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom(), $urandom()};
      rb = pick_operand(ra);
      if ($urandom_range(0, 3) == 0) ra = pick_operand(rb);
      step($sformatf("rnd%0d", n), ($urandom_range(0, 3) != 0), ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
